// File: rtl/coproc_pkg.sv
// coproc_pkg: shared definitions for the UART coprocessor sequencer.
//   state_t        - sequencer FSM encoding (3 bits)
//   CMD_*          - bit positions inside the command byte
//   ERR_BYTE_DEFAULT - byte returned when a command byte is rejected
package coproc_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX_PAYLOAD = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT       = 3'd3,
    S_TX         = 3'd4,
    S_ERR        = 3'd5
  } state_t;

  // Command byte: [2:0] mode, [6:3] reserved (must be zero), [7] batch.
  localparam int CMD_MODE_LSB  = 0;
  localparam int CMD_MODE_MSB  = 2;
  localparam int CMD_RSVD_LSB  = 3;
  localparam int CMD_RSVD_MSB  = 6;
  localparam int CMD_BATCH_BIT = 7;

  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

endpackage

// File: rtl/coproc_uart_sequencer_byte_serializer.sv
// byte_serializer: parallel-load, MSB-first byte shift register feeding a
// byte transmitter.
//
// Handshake: a byte transfers on every rising clk edge where
// tx_valid && tx_ready. While tx_valid is high and tx_ready is low, tx_data
// and tx_valid hold their values. tx_valid never drops without a transfer.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   load          - parallel load of load_data / load_len (starts a burst)
//   load_data     - bytes to send, first byte in the top 8 bits
//   load_len      - number of bytes to send from the top of load_data
//   tx_data       - current byte (top byte of the shift register)
//   tx_valid      - tx_data is valid
//   tx_ready      - consumer accepts the byte
//   done          - high in the cycle whose edge transfers the last byte
module byte_serializer #(
  parameter  int NBYTES = 16,
  localparam int CW     = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [8*NBYTES-1:0]   load_data,
  input  logic [CW-1:0]         load_len,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done
);

  logic [8*NBYTES-1:0] shreg;
  logic [CW-1:0]       remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      remaining <= '0;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= load_len;
      tx_valid  <= (load_len != '0);
    end else if (tx_valid && tx_ready) begin
      shreg     <= {shreg[8*NBYTES-9:0], 8'h00};
      remaining <= remaining - 1'b1;
      if (remaining == CW'(1)) begin
        tx_valid <= 1'b0;
      end
    end
  end

  assign tx_data = shreg[8*NBYTES-1 -: 8];
  assign done    = tx_valid && tx_ready && (remaining == CW'(1));

endmodule

// File: rtl/coproc_uart_sequencer.sv
// coproc_uart_sequencer: front-end controller between a UART byte
// receiver/transmitter and the coprocessor. Collects a command byte plus
// DIN_BYTES payload bytes into din, pulses din_valid, waits WAIT_CYCLES,
// captures dout and returns it MSB-first over the tx byte handshake.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   rx_data, rx_valid  - received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_ready - outgoing byte handshake (valid/ready)
//   din, din_valid     - coprocessor input word and one-cycle issue pulse
//   dout               - coprocessor result
//   control            - coprocessor mode, {3'b0, cmd[2:0]}
//   busy               - high whenever the FSM is not IDLE
//   frames_done        - completed frames, wraps
//   drop_count         - rx bytes ignored while busy, saturates at 255
//   dbg_state          - current FSM state
module coproc_uart_sequencer
  import coproc_pkg::*;
#(
  parameter int         DIN_BYTES   = 16,
  parameter int         DOUT_BYTES  = 16,
  parameter int         WAIT_CYCLES = 64,
  parameter int         RX_TIMEOUT  = 1_000_000,
  parameter logic [7:0] ERR_BYTE    = ERR_BYTE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [8*DIN_BYTES-1:0]  din,
  output logic                    din_valid,
  input  logic [8*DOUT_BYTES-1:0] dout,
  output logic [5:0]              control,
  output logic                    busy,
  output logic [15:0]             frames_done,
  output logic [7:0]              drop_count,
  output logic [2:0]              dbg_state
);

  localparam int IW = $clog2(DIN_BYTES + 1);
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int LW = $clog2(DOUT_BYTES + 1);

  state_t        state;
  logic          batch;
  logic [IW-1:0] byte_idx;
  logic [TW-1:0] idle_cnt;
  logic [15:0]   wait_cnt;

  logic                    ser_load;
  logic [8*DOUT_BYTES-1:0] ser_data;
  logic [LW-1:0]           ser_len;
  logic                    ser_done;

  logic cmd_bad;
  logic wait_last;
  logic drop_state;

  assign cmd_bad    = (rx_data[CMD_RSVD_MSB:CMD_RSVD_LSB] != '0);
  assign wait_last  = (wait_cnt == 16'(WAIT_CYCLES - 1));
  assign drop_state = (state == S_ISSUE) || (state == S_WAIT) ||
                      (state == S_TX)    || (state == S_ERR);

  // Serializer loads: the error byte the same edge a bad command is seen,
  // or the coprocessor result on the last WAIT cycle of a non-batch frame.
  // Loading in the same edge as the state change makes tx_valid rise in
  // the first cycle of TX / ERR.
  always_comb begin
    ser_load = 1'b0;
    ser_data = '0;
    ser_len  = '0;
    if ((state == S_IDLE) && rx_valid && cmd_bad) begin
      ser_load = 1'b1;
      ser_data = {ERR_BYTE, {(8*DOUT_BYTES-8){1'b0}}};
      ser_len  = LW'(1);
    end else if ((state == S_WAIT) && wait_last && !batch) begin
      ser_load = 1'b1;
      ser_data = dout;
      ser_len  = LW'(DOUT_BYTES);
    end
  end

  byte_serializer #(
    .NBYTES (DOUT_BYTES)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (ser_data),
    .load_len  (ser_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      din         <= '0;
      din_valid   <= 1'b0;
      control     <= '0;
      batch       <= 1'b0;
      byte_idx    <= '0;
      idle_cnt    <= '0;
      wait_cnt    <= '0;
      frames_done <= '0;
      drop_count  <= '0;
    end else begin
      din_valid <= 1'b0;

      if (rx_valid && drop_state && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if (cmd_bad) begin
              state <= S_ERR;
            end else begin
              control  <= {3'b000, rx_data[CMD_MODE_MSB:CMD_MODE_LSB]};
              batch    <= rx_data[CMD_BATCH_BIT];
              byte_idx <= '0;
              idle_cnt <= '0;
              state    <= S_RX_PAYLOAD;
            end
          end
        end

        S_RX_PAYLOAD: begin
          if (rx_valid) begin
            din      <= {din[8*DIN_BYTES-9:0], rx_data};
            idle_cnt <= '0;
            if (byte_idx == IW'(DIN_BYTES - 1)) begin
              din_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (idle_cnt == TW'(RX_TIMEOUT - 1)) begin
            // Abandon the partial frame; din and control keep what they hold.
            idle_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_last) begin
            if (batch) begin
              frames_done <= frames_done + 16'd1;
              state       <= S_IDLE;
            end else begin
              state <= S_TX;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_TX: begin
          if (ser_done) begin
            frames_done <= frames_done + 16'd1;
            state       <= S_IDLE;
          end
        end

        S_ERR: begin
          if (ser_done) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: doc/coproc_uart_sequencer.md
Name: coproc_uart_sequencer

Overview:
- Front-end controller for the UART coprocessor datapath. Sits between the UART byte receiver/transmitter and the coprocessor.
- Assembles command and payload bytes into one din word, drives the control mode, and pulses din_valid once per frame.
- Waits a programmed compute window, captures dout, then serialises it back out over the TX byte handshake.
- Handles frame timeout, malformed commands and a compute-only batch mode.

Parameters:
- DIN_BYTES, 16, payload bytes per frame; din width = 8*DIN_BYTES.
- DOUT_BYTES, 16, result bytes returned; dout width = 8*DOUT_BYTES.
- WAIT_CYCLES, 64, cycles from the din_valid pulse to dout capture (range 2..65535).
- RX_TIMEOUT, 1_000_000, idle cycles in RX_PAYLOAD before the frame is aborted.
- ERR_BYTE, 8'hEE, single byte sent when a command byte is rejected.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- rx_data, input, 8, received byte.
- rx_valid, input, 1, one-cycle strobe; rx_data is valid.
- tx_data, output, 8, byte to transmit.
- tx_valid, output, 1, tx_data is valid; held until accepted.
- tx_ready, input, 1, transmitter accepts the byte when tx_valid && tx_ready.
- din, output, 8*DIN_BYTES, word to the coprocessor.
- din_valid, output, 1, one-cycle issue pulse.
- dout, input, 8*DOUT_BYTES, coprocessor result.
- control, output, 6, coprocessor mode; [2:0] = cmd[2:0], [5:3] = 0.
- busy, output, 1, high in every state except IDLE.
- frames_done, output, 16, completed frames; wraps.
- drop_count, output, 8, rx bytes ignored; saturates at 255.

Behaviour:
- Reset: state=IDLE. din=0, din_valid=0, control=0, tx_valid=0, tx_data=0, busy=0, frames_done=0, drop_count=0, all counters 0. A reset mid-frame abandons the frame with no partial TX.
- FSM states: IDLE, RX_PAYLOAD, ISSUE, WAIT, TX, ERR.
- Command byte layout: [2:0] mode, [6:3] reserved (must be 0), [7] batch (1 = skip TX).
- IDLE: on rx_valid, latch the command byte.
  - Reserved bits nonzero -> ERR.
  - Otherwise control[2:0] <= cmd[2:0], byte index <= 0, go to RX_PAYLOAD.
- RX_PAYLOAD:
  - Each rx_valid shifts the byte in MSB-first; the first payload byte lands in din[8*DIN_BYTES-1 -: 8]. The idle counter clears.
  - After byte DIN_BYTES-1 is accepted, go to ISSUE.
  - Idle counter reaching RX_TIMEOUT -> IDLE. din and control keep their last values. frames_done is unchanged.
- ISSUE: din_valid=1 for exactly this one cycle. Wait counter <= 0. Next state is WAIT.
- WAIT:
  - Counter increments every cycle. din and control stay stable.
  - When the counter reaches WAIT_CYCLES-1, capture dout into the TX shift register.
  - Batch=1: frames_done++, go to IDLE. Batch=0: go to TX.
- TX:
  - tx_data = current MSB byte; tx_valid=1.
  - On tx_valid && tx_ready, shift left 8 and increment the byte count.
  - After DOUT_BYTES accepts: tx_valid=0, frames_done++, go to IDLE.
  - tx_data and tx_valid are registered and must not change while tx_valid && !tx_ready.
- ERR: present ERR_BYTE with tx_valid=1 until accepted, then go to IDLE. frames_done is unchanged.
- rx_valid in ISSUE, WAIT, TX or ERR: the byte is dropped and drop_count increments, saturating at 255.
- Single-cycle IDLE turnaround: a byte arriving the cycle after returning to IDLE is accepted as a command.
- control holds its value between frames and changes only on command capture. A reserved-bit reject leaves control unchanged.
- Latency, batch=0: the last payload byte is accepted in cycle 0, din_valid rises in cycle 1, and dout is captured in cycle 1+WAIT_CYCLES. tx_valid is high from cycle 2+WAIT_CYCLES.

Decomposition:
- Shared package coproc_pkg holds:
  - state encoding (localparams S_IDLE..S_ERR, 3 bits);
  - command bit positions CMD_MODE_LSB/MSB, CMD_RSVD_LSB/MSB, CMD_BATCH_BIT;
  - ERR_BYTE default.
- One natural sub-module: byte_serializer, a parallel-load, MSB-first shift register with a valid/ready byte output and a done flag. Both TX and ERR use it; ERR is a 1-byte load.

Test Plan:
- Normal frame, WAIT_CYCLES=4, tx_ready tied 1: cmd 0x00 + 16 payload bytes 0x00..0x0F -> din=128'h000102030405060708090A0B0C0D0E0F; din_valid high for 1 cycle; 16 TX bytes equal the stubbed dout, MSB first; frames_done=1.
- TX backpressure: dout stub 128'hA5..A5 (all bytes A5), cmd 0x03, tx_ready toggling 1-in-3 -> 16 bytes of 0xA5 with no duplicates or skips; tx_data stable while stalled; control=6'b000011.
- Batch mode: cmd 0x81 + 16 bytes -> one din_valid pulse, no tx_valid, frames_done increments, busy drops WAIT_CYCLES+2 cycles after the last byte.
- Reject: cmd 0x08 -> single TX byte 0xEE; control unchanged; the next valid frame is processed normally.
- Timeout, RX_TIMEOUT=20: cmd 0x00 + 5 bytes then silence -> IDLE after 20 idle cycles, no din_valid; the next byte is treated as a command.
- Drops and reset: 3 rx bytes during WAIT -> drop_count=3 and output unchanged; assert rst mid-TX -> all outputs return to reset values the next cycle.
